// File: rtl/stream_mux_if.sv
// rtl/stream_mux_if.sv - stream bundle between N producers, the mux and one consumer
interface stream_mux_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 8
);
    localparam int SEL_W = $clog2(NUM_CH);

    logic [NUM_CH*DATA_WIDTH-1:0] ch_data_i;
    logic [NUM_CH-1:0]            ch_valid_i;
    logic [NUM_CH-1:0]            ch_last_i;
    logic [NUM_CH-1:0]            ch_ready_o;
    logic [DATA_WIDTH-1:0]        out_data_o;
    logic                         out_valid_o;
    logic                         out_last_o;
    logic [SEL_W-1:0]             out_chan_o;
    logic                         out_ready_i;

    // master is the mux itself; slave is the producer/consumer side
    modport master (
        input  ch_data_i, ch_valid_i, ch_last_i, out_ready_i,
        output ch_ready_o, out_data_o, out_valid_o, out_last_o, out_chan_o
    );

    modport slave (
        output ch_data_i, ch_valid_i, ch_last_i, out_ready_i,
        input  ch_ready_o, out_data_o, out_valid_o, out_last_o, out_chan_o
    );
endinterface

// File: rtl/stream_mux.sv
// rtl/stream_mux.sv - N-channel packet-locked stream mux, manual or round-robin
module stream_mux #(
    parameter int  DATA_WIDTH = 32,
    parameter int  NUM_CH     = 8,
    localparam int SEL_W      = $clog2(NUM_CH)
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    input  logic             mode_i,
    input  logic [SEL_W-1:0] selector_i,
    output logic             busy_o,
    stream_mux_if.master     bus
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           state;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] grant;
    logic [SEL_W-1:0] grant_next;
    logic [SEL_W-1:0] rr_pick;
    logic [SEL_W-1:0] idx;
    logic             mode_q;
    logic             rr_found;
    logic             sel_ok;
    logic             accept;

    assign sel_ok     = (int'(sel_q) < NUM_CH) && bus.ch_valid_i[sel_q];
    assign grant_next = (int'(grant) == NUM_CH - 1) ? '0 : grant + 1'b1;
    assign busy_o     = (state == LOCKED);

    // Walk downward so the channel closest to rr_ptr is the last one written
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        idx      = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = SEL_W'((int'(rr_ptr) + i) % NUM_CH);
            if (bus.ch_valid_i[idx]) begin
                rr_found = 1'b1;
                rr_pick  = idx;
            end
        end
    end

    always_comb begin
        bus.ch_ready_o = '0;
        if (state == LOCKED)
            bus.ch_ready_o[grant] = !bus.out_valid_o || bus.out_ready_i;
    end

    assign accept = (state == LOCKED) && bus.ch_valid_i[grant] && bus.ch_ready_o[grant];

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            state           <= IDLE;
            sel_q           <= '0;
            rr_ptr          <= '0;
            grant           <= '0;
            mode_q          <= 1'b0;
            bus.out_data_o  <= '0;
            bus.out_valid_o <= 1'b0;
            bus.out_last_o  <= 1'b0;
            bus.out_chan_o  <= '0;
        end else begin
            sel_q <= selector_i;

            if (accept) begin
                bus.out_data_o  <= bus.ch_data_i[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
                bus.out_last_o  <= bus.ch_last_i[grant];
                bus.out_chan_o  <= grant;
                bus.out_valid_o <= 1'b1;
                if (bus.ch_last_i[grant]) begin
                    state <= IDLE;
                    if (mode_q)
                        rr_ptr <= grant_next;
                end
            end else if (bus.out_ready_i) begin
                bus.out_valid_o <= 1'b0;
            end

            // mode is latched at grant so a mid-packet change cannot alter the pointer update
            if (state == IDLE) begin
                if (!mode_i && sel_ok) begin
                    grant  <= sel_q;
                    mode_q <= 1'b0;
                    state  <= LOCKED;
                end else if (mode_i && rr_found) begin
                    grant  <= rr_pick;
                    mode_q <= 1'b1;
                    state  <= LOCKED;
                end
            end
        end
    end
endmodule

// File: tb/tb_stream_mux.sv
// tb/tb_stream_mux.sv - directed bench for stream_mux with a beat scoreboard
`timescale 1ns/1ps
module tb_stream_mux;
    localparam int DW  = 32;
    localparam int NC  = 8;
    localparam int NC6 = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       arstn    = 1'b0;
    logic       mode     = 1'b0;
    logic [2:0] selector = '0;
    logic       busy;
    stream_mux_if #(.DATA_WIDTH(DW), .NUM_CH(NC)) bus8 ();
    stream_mux #(.DATA_WIDTH(DW), .NUM_CH(NC)) dut (
        .clk_i(clk), .arstn_i(arstn), .mode_i(mode), .selector_i(selector),
        .busy_o(busy), .bus(bus8)
    );

    logic       arstn6 = 1'b0;
    logic       mode6  = 1'b0;
    logic [2:0] sel6   = '0;
    logic       busy6;
    stream_mux_if #(.DATA_WIDTH(DW), .NUM_CH(NC6)) bus6 ();
    stream_mux #(.DATA_WIDTH(DW), .NUM_CH(NC6)) dut6 (
        .clk_i(clk), .arstn_i(arstn6), .mode_i(mode6), .selector_i(sel6),
        .busy_o(busy6), .bus(bus6)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  chan;
        logic        last;
    } beat_t;

    beat_t       exp_q [$];
    logic [32:0] mem [NC][32];
    int          head [NC];
    int          tail [NC];

    // Queue a beat on channel k and record it as the next beat the consumer must see
    task automatic send(input int k, input logic [31:0] d, input logic l);
        beat_t b;
        mem[k][tail[k] % 32] = {l, d};
        tail[k]++;
        b.data = d;
        b.chan = 3'(k);
        b.last = l;
        exp_q.push_back(b);
    endtask

    // Producers: each channel presents its queue head and holds it until a handshake
    initial begin
        logic [NC-1:0] xfer;
        bus8.ch_valid_i = '0;
        bus8.ch_last_i  = '0;
        bus8.ch_data_i  = '0;
        forever begin
            @(negedge clk);
            xfer = bus8.ch_valid_i & bus8.ch_ready_o;
            @(posedge clk);
            #2;
            for (int k = 0; k < NC; k++) begin
                if (xfer[k]) head[k]++;
                if (head[k] != tail[k]) begin
                    bus8.ch_valid_i[k]          = 1'b1;
                    bus8.ch_last_i[k]           = mem[k][head[k] % 32][32];
                    bus8.ch_data_i[k*DW +: DW]  = mem[k][head[k] % 32][31:0];
                end else begin
                    bus8.ch_valid_i[k] = 1'b0;
                    bus8.ch_last_i[k]  = 1'b0;
                end
            end
        end
    end

    // Every cycle: ready rule, output hold under backpressure, consumed beats vs scoreboard
    initial begin
        beat_t       b;
        logic        hold_v = 1'b0;
        logic [31:0] hold_data = '0;
        logic [2:0]  hold_chan = '0;
        logic        hold_last = 1'b0;
        forever begin
            @(negedge clk);
            chk("ready_onehot", $onehot0(bus8.ch_ready_o), 1);
            chk("ready_rule", bus8.ch_ready_o != 0,
                busy && (!bus8.out_valid_o || bus8.out_ready_i));
            if (hold_v) begin
                chk("hold_valid", bus8.out_valid_o, 1);
                chk("hold_data", bus8.out_data_o, hold_data);
                chk("hold_chan", bus8.out_chan_o, hold_chan);
                chk("hold_last", bus8.out_last_o, hold_last);
            end
            hold_v    = bus8.out_valid_o && !bus8.out_ready_i;
            hold_data = bus8.out_data_o;
            hold_chan = bus8.out_chan_o;
            hold_last = bus8.out_last_o;
            if (bus8.out_valid_o && bus8.out_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_data", bus8.out_data_o, b.data);
                    chk("beat_chan", bus8.out_chan_o, b.chan);
                    chk("beat_last", bus8.out_last_o, b.last);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached with %0d beats outstanding", exp_q.size());
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        @(negedge clk);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy || bus8.out_valid_o) && n < budget) begin
            step();
            n++;
        end
        chk({name, "_timeout"}, n >= budget, 0);
    endtask

    initial begin
        int seen;
        int last_c;

        bus8.out_ready_i = 1'b1;
        bus6.out_ready_i = 1'b1;
        bus6.ch_data_i   = '0;
        bus6.ch_valid_i  = '0;
        bus6.ch_last_i   = '0;

        // Reset with every channel valid
        for (int k = 0; k < NC; k++) send(k, 32'h10 + k, 1'b1);
        repeat (3) step();
        probe();
        chk("rst_valid", bus8.out_valid_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", bus8.ch_ready_o, 0);
        chk("rst_data", bus8.out_data_o, 0);
        chk("rst_chan", bus8.out_chan_o, 0);
        chk("rst_last", bus8.out_last_o, 0);
        step();
        arstn = 1'b1;
        step(); probe();
        chk("rel_busy", busy, 1);
        chk("rel_ready", bus8.ch_ready_o, 8'h01);
        step(); probe();
        chk("rel_out_valid", bus8.out_valid_o, 1);
        chk("rel_out_data", bus8.out_data_o, 32'h10);
        chk("rel_busy_after", busy, 0);
        step();
        mode = 1'b1;
        wait_drain("flush", 60);

        // Manual 3-beat packet on channel 5
        step();
        mode = 1'b0;
        selector = 3'd5;
        send(5, 32'hA0, 1'b0);
        send(5, 32'hA1, 1'b0);
        send(5, 32'hA2, 1'b1);
        step(); probe();
        chk("man_t1_busy", busy, 0);
        step(); probe();
        chk("man_t2_busy", busy, 1);
        chk("man_t2_ready", bus8.ch_ready_o, 8'h20);
        step(); probe();
        chk("man_a0_valid", bus8.out_valid_o, 1);
        chk("man_a0_data", bus8.out_data_o, 32'hA0);
        chk("man_a0_chan", bus8.out_chan_o, 5);
        chk("man_a0_last", bus8.out_last_o, 0);
        step(); probe();
        chk("man_a1_data", bus8.out_data_o, 32'hA1);
        chk("man_a1_last", bus8.out_last_o, 0);
        step(); probe();
        chk("man_a2_data", bus8.out_data_o, 32'hA2);
        chk("man_a2_last", bus8.out_last_o, 1);
        chk("man_a2_busy", busy, 0);
        wait_drain("manual", 20);

        // Packet lock: channel 6 requests during a channel-2 packet
        step();
        selector = 3'd2;
        for (int i = 0; i < 4; i++) send(2, 32'hB0 + i, i == 3);
        step(); step(); step();
        selector = 3'd6;
        send(6, 32'hC0, 1'b1);
        probe();
        chk("lock_b0_data", bus8.out_data_o, 32'hB0);
        chk("lock_b0_chan", bus8.out_chan_o, 2);
        step(); probe();
        chk("lock_b1_no6", bus8.ch_ready_o[6], 0);
        step(); probe();
        chk("lock_b2_no6", bus8.ch_ready_o[6], 0);
        step(); probe();
        chk("lock_b3_data", bus8.out_data_o, 32'hB3);
        chk("lock_b3_busy", busy, 0);
        step(); probe();
        chk("lock_g6_busy", busy, 1);
        chk("lock_g6_ready", bus8.ch_ready_o, 8'h40);
        chk("lock_bubble", bus8.out_valid_o, 0);
        step(); probe();
        chk("lock_c0_data", bus8.out_data_o, 32'hC0);
        chk("lock_c0_chan", bus8.out_chan_o, 6);
        wait_drain("lock", 20);

        // Round-robin fairness with single-beat packets
        step();
        mode = 1'b1;
        for (int k = 0; k < NC; k++) send(k, 32'h100 + k, 1'b1);
        send(0, 32'h200, 1'b1);
        seen   = 0;
        last_c = 0;
        for (int c = 0; c < 30 && seen < 9; c++) begin
            step(); probe();
            if (bus8.out_valid_o) begin
                chk("rr_chan", bus8.out_chan_o, seen % NC);
                if (seen > 0) chk("rr_gap", c - last_c, 2);
                last_c = c;
                seen++;
            end
        end
        chk("rr_count", seen, 9);
        wait_drain("rr", 20);

        // Backpressure: out_ready 1,0,0,1 mid-packet
        step();
        mode = 1'b0;
        selector = 3'd3;
        for (int i = 0; i < 4; i++) send(3, 32'hD0 + i, i == 3);
        step(); step(); step(); probe();
        chk("bp_d0_data", bus8.out_data_o, 32'hD0);
        step();
        bus8.out_ready_i = 1'b0;
        probe();
        chk("bp_lo1_data", bus8.out_data_o, 32'hD1);
        chk("bp_lo1_ready", bus8.ch_ready_o, 0);
        step(); probe();
        chk("bp_lo2_data", bus8.out_data_o, 32'hD1);
        chk("bp_lo2_valid", bus8.out_valid_o, 1);
        step();
        bus8.out_ready_i = 1'b1;
        probe();
        chk("bp_hi_data", bus8.out_data_o, 32'hD1);
        chk("bp_hi_ready", bus8.ch_ready_o, 8'h08);
        step(); probe();
        chk("bp_d2_data", bus8.out_data_o, 32'hD2);
        step(); probe();
        chk("bp_d3_data", bus8.out_data_o, 32'hD3);
        chk("bp_d3_last", bus8.out_last_o, 1);
        wait_drain("bp", 20);

        // Six-channel instance: reset during beat 2, then out-of-range selector
        step();
        arstn6 = 1'b1;
        bus6.ch_valid_i = 6'h01;
        bus6.ch_data_i[0 +: DW] = 32'hE0;
        step(); probe();
        chk("r6_grant", busy6, 1);
        step();
        bus6.ch_data_i[0 +: DW] = 32'hE1;
        arstn6 = 1'b0;
        probe();
        chk("r6_e0_data", bus6.out_data_o, 32'hE0);
        chk("r6_e0_valid", bus6.out_valid_o, 1);
        step();
        arstn6 = 1'b1;
        bus6.ch_valid_i = '0;
        sel6 = 3'd7;
        probe();
        chk("r6_rst_valid", bus6.out_valid_o, 0);
        chk("r6_rst_busy", busy6, 0);
        chk("r6_rst_ready", bus6.ch_ready_o, 0);
        chk("r6_rst_data", bus6.out_data_o, 0);
        step();
        bus6.ch_valid_i = 6'h3F;
        for (int c = 0; c < 5; c++) begin
            step(); probe();
            chk("oor_busy", busy6, 0);
            chk("oor_valid", bus6.out_valid_o, 0);
            chk("oor_ready", bus6.ch_ready_o, 0);
        end

        chk("exp_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
